// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if: parallel request side and serial line of the UART transmitter.
// Handshake: a request is taken at a rising clock edge where DATA_VALID=1 and the
// transmitter is idle (BUSY=0 in the preceding cycle). There is no ready signal;
// BUSY high means DATA_VALID is ignored. P_DATA, PAR_EN and PAR_TYP only matter at
// the accepting edge.
interface uart_tx_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  BUSY;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  TX_OUT, BUSY
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output TX_OUT, BUSY
  );
endinterface

// File: rtl/uart_tx_core.sv
// uart_tx_core: one bit per CLK cycle UART transmitter.
// Frame: start(0), DATA_WIDTH payload bits LSB first, optional parity, stop bit(s) at 1.
// Optional feature: define TX_TWO_STOP_EN to send two stop bits (adds state STOP2).
// TX_OUT and BUSY are registered: they are decoded from the next state so the
// line changes on the same edge the state does.
module uart_tx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_core_if.slave  bus,
  output logic [2:0]     state_dbg
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

`ifdef TX_TWO_STOP_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`endif

  state_t                state_q, state_nxt;
  logic [CW-1:0]         cnt_q, cnt_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  tx_q, tx_nxt;
  logic                  busy_q, busy_nxt;
  logic                  accept;

  assign accept     = (state_q == IDLE) && bus.DATA_VALID;
  assign bus.TX_OUT = tx_q;
  assign bus.BUSY   = busy_q;
  assign state_dbg  = state_q;

  // Next-state, bit counter and registered-output decode.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = '0;
    tx_nxt    = 1'b1;
    busy_nxt  = 1'b1;
    case (state_q)
      IDLE:   if (bus.DATA_VALID) state_nxt = START;
      START:  state_nxt = DATA;
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          state_nxt = par_en_q ? PARITY : STOP;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      PARITY: state_nxt = STOP;
`ifdef TX_TWO_STOP_EN
      STOP:   state_nxt = STOP2;
      STOP2:  state_nxt = IDLE;
`else
      STOP:   state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase

    // Line level for the cycle that follows this edge.
    case (state_nxt)
      IDLE:    busy_nxt = 1'b0;
      START:   tx_nxt   = 1'b0;
      DATA:    tx_nxt   = data_q[cnt_nxt];
      PARITY:  tx_nxt   = par_bit_q;
      default: tx_nxt   = 1'b1;
    endcase
  end

  // State, counter and line registers; reset drops the line to idle at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      tx_q    <= tx_nxt;
      busy_q  <= busy_nxt;
    end
  end

  // Frame capture: payload and parity are frozen at acceptance.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (accept) begin
      data_q    <= bus.P_DATA;
      par_en_q  <= bus.PAR_EN;
      par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: randomized and directed stimulus against a frame-queue model.
module tb_uart_tx_core;

  localparam int DW = 8;

  logic       clk;
  logic       rst_n;
  logic [2:0] state_dbg;

  uart_tx_core_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_core #(.DATA_WIDTH(DW)) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: expected line level for each upcoming busy cycle.
  logic exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a whole frame as a list of line levels.
  task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      exp_q.push_back(d[i]);
      ones += d[i];
    end
    if (pe) exp_q.push_back(((ones % 2) == 1) != pt);
    exp_q.push_back(1'b1);
`ifdef TX_TWO_STOP_EN
    exp_q.push_back(1'b1);
`endif
  endtask

  // One cycle: check outputs at the falling edge, then drive the next inputs.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic pe, input logic pt);
    logic et, eb, was_idle;
    @(negedge clk);
    was_idle = (exp_q.size() == 0);
    if (!was_idle) begin
      et = exp_q.pop_front();
      eb = 1'b1;
    end else begin
      et = 1'b1;
      eb = 1'b0;
    end
    check("tx_out", bus.TX_OUT, et);
    check("busy", bus.BUSY, eb);
    bus.DATA_VALID = v;
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    if (was_idle && v) push_frame(d, pe, pt);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, DW'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Send one frame with a single-cycle request; inputs scramble afterwards.
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt, input int tail);
    cycle(1'b1, d, pe, pt);
    idle_cycles(tail);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.DATA_VALID = 1'b0;
    bus.P_DATA     = '0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    #12;
    check("reset_tx", bus.TX_OUT, 1'b1);
    check("reset_busy", bus.BUSY, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0xA5 without parity, then even and odd parity.
    send(8'hA5, 1'b0, 1'b0, 14);
    send(8'hA5, 1'b1, 1'b0, 14);
    send(8'hA5, 1'b1, 1'b1, 14);

    // 0x07 even parity; payload forced to 0 during the frame.
    cycle(1'b1, 8'h07, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Request held high for 30 cycles: back-to-back frames.
    for (int i = 0; i < 30; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'($urandom));
    idle_cycles(14);

    // Reset during data bit 3.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    idle_cycles(5);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", bus.TX_OUT, 1'b1);
    check("abort_busy", bus.BUSY, 1'b0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(6);

    // Immediate request after release, then random traffic.
    send(8'hFF, 1'b0, 1'b0, 13);
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) == 0), DW'($urandom), 1'($urandom), 1'($urandom));
    end
    idle_cycles(14);
    check("drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
